// File: rtl/usrt_rx_if.sv
// Serial receiver bus bundle: bit clock, data line, consumer handshake and
// status outputs. The receiver connects through the slave modport.
interface usrt_rx_if;
  logic       i_Bclk;
  logic       i_Rx;
  logic       i_Ack;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Frame_err;
  logic       o_Parity_err;
  logic       o_Overrun;

  modport master (
    output i_Bclk, i_Rx, i_Ack,
    input  o_Data, o_Valid, o_Frame_err, o_Parity_err, o_Overrun
  );

  modport slave (
    input  i_Bclk, i_Rx, i_Ack,
    output o_Data, o_Valid, o_Frame_err, o_Parity_err, o_Overrun
  );
endinterface

// File: rtl/usrt_rx.sv
// Synchronous serial receiver clocked by an external bit clock (i_Bclk).
// Even parity support compiled in with `define USRT_RX_PARITY_EN.
module usrt_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic      i_Pclk,
  input  logic      i_Rst_n,
  usrt_rx_if.slave  bus
);

`ifdef USRT_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;
`endif

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef USRT_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 mism_q, mism_d;
`endif

  logic bclk_s1_q, bclk_s2_q, bclk_dly_q;
  logic rx_s1_q, rx_s2_q;
  logic bit_tick;
  logic deliver;
  logic [7:0] shift_ext;

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bclk_s1_q  <= 1'b0;
      bclk_s2_q  <= 1'b0;
      bclk_dly_q <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      bclk_s1_q  <= bus.i_Bclk;
      bclk_s2_q  <= bclk_s1_q;
      bclk_dly_q <= bclk_s2_q;
      rx_s1_q    <= bus.i_Rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

  assign bit_tick = bclk_s2_q & ~bclk_dly_q;

  always_comb begin
    shift_ext                = '0;
    shift_ext[DATA_BITS-1:0] = shift_q;
  end

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef USRT_RX_PARITY_EN
      perr_q  <= 1'b0;
      mism_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef USRT_RX_PARITY_EN
      perr_q  <= perr_d;
      mism_q  <= mism_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
`ifdef USRT_RX_PARITY_EN
    perr_d  = 1'b0;
    mism_d  = mism_q;
`endif

    if (bit_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s2_q) begin
            state_d = DATA;
            cnt_d   = '0;
`ifdef USRT_RX_PARITY_EN
            mism_d  = 1'b0;
`endif
          end
        end
        DATA: begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == LAST_BIT) begin
`ifdef USRT_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef USRT_RX_PARITY_EN
        PARITY: begin
          mism_d  = rx_s2_q ^ (^shift_q);
          state_d = STOP;
        end
`endif
        STOP: begin
          ferr_d  = ~rx_s2_q;
`ifdef USRT_RX_PARITY_EN
          perr_d  = mism_q;
          deliver = rx_s2_q & ~mism_q;
`else
          deliver = rx_s2_q;
`endif
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // An ack landing in the delivery cycle frees the slot, so the new byte wins
    if (deliver) begin
      if (!valid_q || bus.i_Ack) begin
        data_d = shift_ext;
      end else begin
        ovr_d = 1'b1;
      end
      valid_d = 1'b1;
    end else if (bus.i_Ack) begin
      valid_d = 1'b0;
    end
  end

  assign bus.o_Data      = data_q;
  assign bus.o_Valid     = valid_q;
  assign bus.o_Frame_err = ferr_q;
  assign bus.o_Overrun   = ovr_q;
`ifdef USRT_RX_PARITY_EN
  assign bus.o_Parity_err = perr_q;
`else
  assign bus.o_Parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usrt_rx.sv
// Scoreboard bench for usrt_rx: Pclk 10 MHz, Bclk = Pclk/20 free-running.
// Honours USRT_RX_PARITY_EN the same way as the design.
module tb_usrt_rx;
  localparam int unsigned DATA_BITS = 8;
`ifdef USRT_RX_PARITY_EN
  localparam int unsigned FRAME_LEN = DATA_BITS + 3;
`else
  localparam int unsigned FRAME_LEN = DATA_BITS + 2;
`endif

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic       ovr;
    logic       dlv;
    logic [7:0] data;
  } ev_t;

  logic pclk;
  logic rst_n;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

`ifdef USRT_RX_PARITY_EN
  logic par_flip;
`endif

  usrt_rx_if bus ();

  usrt_rx #(.DATA_BITS(DATA_BITS)) dut (
    .i_Pclk  (pclk),
    .i_Rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial begin
    pclk = 1'b0;
    forever #50 pclk = ~pclk;
  end

  // Bit clock edges sit 40 ns before a Pclk rising edge, never coincident
  initial begin
    bus.i_Bclk = 1'b0;
    #1010;
    forever #1000 bus.i_Bclk = ~bus.i_Bclk;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish within 3 ms");
    $fatal(1);
  end

  function automatic ev_t mk(input logic f, input logic p, input logic o,
                             input logic d, input logic [7:0] data);
    mk = '{ferr: f, perr: p, ovr: o, dlv: d, data: data};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: any delivery (valid rising or data changing while valid) or pulse
  logic       prev_valid;
  logic [7:0] prev_data;
  always @(negedge pclk) begin
    ev_t got, want;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_data  = 8'h00;
    end else begin
      got.ferr = bus.o_Frame_err;
      got.perr = bus.o_Parity_err;
      got.ovr  = bus.o_Overrun;
      got.dlv  = bus.o_Valid && (!prev_valid || bus.o_Data != prev_data);
      got.data = got.dlv ? bus.o_Data : 8'h00;
      if (got.ferr || got.perr || got.ovr || got.dlv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got ferr=%b perr=%b ovr=%b dlv=%b data=%h, none expected",
                   got.ferr, got.perr, got.ovr, got.dlv, got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event: got ferr=%b perr=%b ovr=%b dlv=%b data=%h expected ferr=%b perr=%b ovr=%b dlv=%b data=%h",
                     got.ferr, got.perr, got.ovr, got.dlv, got.data,
                     want.ferr, want.perr, want.ovr, want.dlv, want.data);
          end
        end
      end
      prev_valid = bus.o_Valid;
      prev_data  = bus.o_Data;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit ack_stop);
    @(negedge bus.i_Bclk) bus.i_Rx = 1'b0;
    for (int i = 0; i < int'(DATA_BITS); i++) begin
      @(negedge bus.i_Bclk) bus.i_Rx = d[i];
    end
`ifdef USRT_RX_PARITY_EN
    @(negedge bus.i_Bclk) bus.i_Rx = (^d[DATA_BITS-1:0]) ^ par_flip;
`endif
    @(negedge bus.i_Bclk) bus.i_Rx = stop_b;
    @(posedge bus.i_Bclk);
    if (ack_stop) begin
      // Stop-bit tick is registered on the third Pclk edge after Bclk rises
      @(posedge pclk);
      @(posedge pclk);
      #1 bus.i_Ack = 1'b1;
      @(posedge pclk);
      #1 bus.i_Ack = 1'b0;
    end
    @(negedge bus.i_Bclk) bus.i_Rx = 1'b1;
  endtask

  task automatic ack_and_check(input string name, input logic [7:0] data_exp);
    @(negedge pclk) bus.i_Ack = 1'b1;
    @(negedge pclk) bus.i_Ack = 1'b0;
    chk({name, "_valid_cleared"}, {7'd0, bus.o_Valid}, 8'h00);
    chk({name, "_data_kept"}, bus.o_Data, data_exp);
  endtask

  initial begin
    logic [7:0] part;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.i_Rx   = 1'b1;
    bus.i_Ack  = 1'b0;
`ifdef USRT_RX_PARITY_EN
    par_flip   = 1'b0;
`endif
    #275;
    chk("rst_data",  bus.o_Data, 8'h00);
    chk("rst_valid", {7'd0, bus.o_Valid}, 8'h00);
    chk("rst_ferr",  {7'd0, bus.o_Frame_err}, 8'h00);
    chk("rst_perr",  {7'd0, bus.o_Parity_err}, 8'h00);
    chk("rst_ovr",   {7'd0, bus.o_Overrun}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge bus.i_Bclk);

    exp_q.push_back(mk(0, 0, 0, 1, 8'hA5));
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_valid", {7'd0, bus.o_Valid}, 8'h01);
    chk("a5_data", bus.o_Data, 8'hA5);
    ack_and_check("a5", 8'hA5);

    exp_q.push_back(mk(1, 0, 0, 0, 8'h00));
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("3c_valid_low", {7'd0, bus.o_Valid}, 8'h00);
    chk("3c_data_kept", bus.o_Data, 8'hA5);

    exp_q.push_back(mk(0, 0, 0, 1, 8'h11));
    exp_q.push_back(mk(0, 0, 1, 0, 8'h00));
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_data", bus.o_Data, 8'h11);
    chk("ovr_valid", {7'd0, bus.o_Valid}, 8'h01);
    ack_and_check("ovr", 8'h11);

    exp_q.push_back(mk(0, 0, 0, 1, 8'h11));
    exp_q.push_back(mk(0, 0, 0, 1, 8'h22));
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    chk("ackdlv_data", bus.o_Data, 8'h22);
    chk("ackdlv_valid", {7'd0, bus.o_Valid}, 8'h01);

    // Partial frame: start plus four data bits, then reset
    part = 8'hF0;
    @(negedge bus.i_Bclk) bus.i_Rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge bus.i_Bclk) bus.i_Rx = part[i];
    end
    @(posedge bus.i_Bclk);
    #300 rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  bus.o_Data, 8'h00);
    chk("mid_rst_valid", {7'd0, bus.o_Valid}, 8'h00);
    chk("mid_rst_ferr",  {7'd0, bus.o_Frame_err}, 8'h00);
    chk("mid_rst_perr",  {7'd0, bus.o_Parity_err}, 8'h00);
    chk("mid_rst_ovr",   {7'd0, bus.o_Overrun}, 8'h00);
    bus.i_Rx = 1'b1;
    #500 rst_n = 1'b1;
    repeat (2) @(negedge bus.i_Bclk);
    exp_q.push_back(mk(0, 0, 0, 1, 8'h5A));
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("post_rst_data", bus.o_Data, 8'h5A);
    ack_and_check("post_rst", 8'h5A);

    // Break: line held low for exactly two frame lengths
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00));
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00));
    @(negedge bus.i_Bclk) bus.i_Rx = 1'b0;
    repeat (2 * FRAME_LEN) @(negedge bus.i_Bclk);
    bus.i_Rx = 1'b1;
    chk("break_valid_low", {7'd0, bus.o_Valid}, 8'h00);
    @(negedge bus.i_Bclk);
    exp_q.push_back(mk(0, 0, 0, 1, 8'hC3));
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("after_break_data", bus.o_Data, 8'hC3);
    ack_and_check("after_break", 8'hC3);

`ifdef USRT_RX_PARITY_EN
    par_flip = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 0, 8'h00));
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_bad_valid", {7'd0, bus.o_Valid}, 8'h00);
    exp_q.push_back(mk(1, 1, 0, 0, 8'h00));
    send_frame(8'h07, 1'b0, 1'b0);
    par_flip = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 8'h07));
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_ok_data", bus.o_Data, 8'h07);
    chk("par_ok_valid", {7'd0, bus.o_Valid}, 8'h01);
`endif

    repeat (3) @(negedge bus.i_Bclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unconsumed expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
